// File: rtl/tl_socket_m1.sv
// rtl/tl_socket_m1.sv - many-to-one TileLink socket: RR-arbitrated A/C/E with burst lock, source-routed B/D.
// Optional concurrent checks are compiled in with TL_SOCKET_M1_ASSERT_EN.

module tl_socket_m1_arb #(
  parameter int N  = 1,
  parameter int LW = 1,
  parameter int PW = 1,
  parameter int CW = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0][PW-1:0] i_payload,
  input  logic [N-1:0][CW-1:0] i_beats_m1,
  output logic [N-1:0]         o_ready,
  output logic                 o_valid,
  output logic [PW-1:0]        o_payload,
  input  logic                 i_ready
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e        r_state, w_state_nxt;
  logic [N-1:0]  r_sel, w_sel_nxt, w_win, w_sel;
  logic [LW-1:0] r_ptr, w_ptr_nxt, w_win_idx, w_lock_idx, w_sel_idx, w_ptr_adv;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_beats, w_rem;
  logic          w_locked, w_fire, w_last;

  // Round-robin search starting at the pointer, wrapping modulo N.
  always_comb begin : rr_pick
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    w_win     = '0;
    w_win_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && i_valid[idx]) begin
        found      = 1'b1;
        w_win[idx] = 1'b1;
        w_win_idx  = LW'(idx);
      end
    end
  end

  always_comb begin
    w_lock_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_sel[i]) w_lock_idx = LW'(i);
    end
  end

  assign w_locked  = (r_state == ST_LOCKED);
  assign w_sel     = w_locked ? r_sel : w_win;
  assign w_sel_idx = w_locked ? w_lock_idx : w_win_idx;

  always_comb begin
    o_payload = '0;
    w_beats   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel[i]) o_payload = o_payload | i_payload[i];
      if (w_win[i]) w_beats = w_beats | i_beats_m1[i];
    end
  end

  assign w_rem     = w_locked ? r_cnt : w_beats;
  assign o_valid   = |(i_valid & w_sel);
  assign o_ready   = {N{i_ready}} & w_sel;
  assign w_fire    = o_valid && i_ready;
  assign w_last    = (w_rem == '0);
  assign w_ptr_adv = (w_sel_idx == LW'(N - 1)) ? '0 : w_sel_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (o_valid) begin
          if (w_fire && w_last) begin
            w_ptr_nxt = w_ptr_adv;
          end else begin
            w_state_nxt = ST_LOCKED;
            w_sel_nxt   = w_win;
            w_cnt_nxt   = w_fire ? w_rem - 1'b1 : w_rem;
          end
        end
      end
      ST_LOCKED: begin
        if (w_fire) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = w_ptr_adv;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef TL_SOCKET_M1_ASSERT_EN
  a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_locked && !(w_fire && w_last)) |=> (r_sel == $past(r_sel)));
  a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (o_valid && !i_ready) |=> $stable(o_payload));
  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_fire && !w_last) |-> (w_rem != '0));
`endif

endmodule

module tl_socket_m1 #(
  parameter int SourceWidth    = 1,
  parameter int SinkWidth      = 1,
  parameter int AddrWidth      = 56,
  parameter int DataWidth      = 64,
  parameter int MaxSize        = 6,
  parameter int NumLinks       = 1,
  parameter int NumSourceRange = 1,
  parameter logic [NumSourceRange-1:0][SourceWidth-1:0] SourceBase = '0,
  parameter logic [NumSourceRange-1:0][SourceWidth-1:0] SourceMask = '0,
  parameter logic [NumSourceRange-1:0][((NumLinks > 1) ? $clog2(NumLinks) : 1)-1:0] SourceLink = '0,
  localparam int LinkWidth = (NumLinks > 1) ? $clog2(NumLinks) : 1,
  localparam int SizeWidth = $clog2(MaxSize + 1),
  localparam int HdrWidth  = 3 + 3 + SizeWidth,
  localparam int APayW     = HdrWidth + SourceWidth + AddrWidth + DataWidth / 8 + 1 + DataWidth,
  localparam int BPayW     = APayW,
  localparam int CPayW     = HdrWidth + SourceWidth + AddrWidth + 1 + DataWidth,
  localparam int DPayW     = HdrWidth + SourceWidth + SinkWidth + 1 + 1 + DataWidth,
  localparam int EPayW     = SinkWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumLinks-1:0][APayW-1:0]   host_a,
  input  logic [NumLinks-1:0]              host_a_valid,
  output logic [NumLinks-1:0]              host_a_ready,
  input  logic [NumLinks-1:0][CPayW-1:0]   host_c,
  input  logic [NumLinks-1:0]              host_c_valid,
  output logic [NumLinks-1:0]              host_c_ready,
  input  logic [NumLinks-1:0][EPayW-1:0]   host_e,
  input  logic [NumLinks-1:0]              host_e_valid,
  output logic [NumLinks-1:0]              host_e_ready,
  output logic [NumLinks-1:0][BPayW-1:0]   host_b,
  output logic [NumLinks-1:0]              host_b_valid,
  input  logic [NumLinks-1:0]              host_b_ready,
  output logic [NumLinks-1:0][DPayW-1:0]   host_d,
  output logic [NumLinks-1:0]              host_d_valid,
  input  logic [NumLinks-1:0]              host_d_ready,
  output logic [APayW-1:0]                 device_a,
  output logic                             device_a_valid,
  input  logic                             device_a_ready,
  output logic [CPayW-1:0]                 device_c,
  output logic                             device_c_valid,
  input  logic                             device_c_ready,
  output logic [EPayW-1:0]                 device_e,
  output logic                             device_e_valid,
  input  logic                             device_e_ready,
  input  logic [BPayW-1:0]                 device_b,
  input  logic                             device_b_valid,
  output logic                             device_b_ready,
  input  logic [DPayW-1:0]                 device_d,
  input  logic                             device_d_valid,
  output logic                             device_d_ready
);

  localparam int LgBytes  = $clog2(DataWidth / 8);
  localparam int CntWidth = (MaxSize > LgBytes) ? MaxSize - LgBytes : 1;

  // Payload layout MSB-first: opcode(3), param(3), size, source, ...
  function automatic logic [CntWidth-1:0] beats_m1(input logic has_data,
                                                   input logic [SizeWidth-1:0] size);
    int n;
    n = 0;
    if (has_data && (int'(size) > LgBytes)) n = (1 << (int'(size) - LgBytes)) - 1;
    return CntWidth'(n);
  endfunction

  function automatic logic [LinkWidth-1:0] route(input logic [SourceWidth-1:0] src);
    route = '0;
    for (int j = 0; j < NumSourceRange; j++) begin
      if ((src & ~SourceMask[j]) == SourceBase[j]) route = SourceLink[j];
    end
  endfunction

  logic [NumLinks-1:0][CntWidth-1:0] w_a_beats, w_c_beats, w_e_beats;
  logic [LinkWidth-1:0]              w_b_dest, w_d_dest;
  logic [NumLinks-1:0]               w_b_oh, w_d_oh;

  always_comb begin
    for (int i = 0; i < NumLinks; i++) begin
      w_a_beats[i] = beats_m1(host_a[i][APayW-1 -: 3] <= 3'd3, host_a[i][APayW-7 -: SizeWidth]);
      w_c_beats[i] = beats_m1((host_c[i][CPayW-1 -: 3] == 3'd5) || (host_c[i][CPayW-1 -: 3] == 3'd7),
                              host_c[i][CPayW-7 -: SizeWidth]);
      w_e_beats[i] = '0;
    end
  end

  tl_socket_m1_arb #(.N(NumLinks), .LW(LinkWidth), .PW(APayW), .CW(CntWidth)) u_arb_a (
    .clk_i(clk_i), .rst_i(rst_i), .i_valid(host_a_valid), .i_payload(host_a),
    .i_beats_m1(w_a_beats), .o_ready(host_a_ready), .o_valid(device_a_valid),
    .o_payload(device_a), .i_ready(device_a_ready));

  tl_socket_m1_arb #(.N(NumLinks), .LW(LinkWidth), .PW(CPayW), .CW(CntWidth)) u_arb_c (
    .clk_i(clk_i), .rst_i(rst_i), .i_valid(host_c_valid), .i_payload(host_c),
    .i_beats_m1(w_c_beats), .o_ready(host_c_ready), .o_valid(device_c_valid),
    .o_payload(device_c), .i_ready(device_c_ready));

  tl_socket_m1_arb #(.N(NumLinks), .LW(LinkWidth), .PW(EPayW), .CW(CntWidth)) u_arb_e (
    .clk_i(clk_i), .rst_i(rst_i), .i_valid(host_e_valid), .i_payload(host_e),
    .i_beats_m1(w_e_beats), .o_ready(host_e_ready), .o_valid(device_e_valid),
    .o_payload(device_e), .i_ready(device_e_ready));

  // Responses route purely on source, which is constant across a D burst.
  assign w_b_dest = route(device_b[BPayW-HdrWidth-1 -: SourceWidth]);
  assign w_d_dest = route(device_d[DPayW-HdrWidth-1 -: SourceWidth]);

  always_comb begin
    for (int i = 0; i < NumLinks; i++) begin
      w_b_oh[i] = (w_b_dest == LinkWidth'(i));
      w_d_oh[i] = (w_d_dest == LinkWidth'(i));
    end
  end

  assign host_b         = {NumLinks{device_b}};
  assign host_b_valid   = {NumLinks{device_b_valid}} & w_b_oh;
  assign device_b_ready = |(host_b_ready & w_b_oh);
  assign host_d         = {NumLinks{device_d}};
  assign host_d_valid   = {NumLinks{device_d_valid}} & w_d_oh;
  assign device_d_ready = |(host_d_ready & w_d_oh);

`ifdef TL_SOCKET_M1_ASSERT_EN
  function automatic logic src_hit(input logic [SourceWidth-1:0] src);
    src_hit = 1'b0;
    for (int j = 0; j < NumSourceRange; j++) begin
      if ((src & ~SourceMask[j]) == SourceBase[j]) src_hit = 1'b1;
    end
  endfunction

  a_b_src_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    device_b_valid |-> src_hit(device_b[BPayW-HdrWidth-1 -: SourceWidth]));
  a_d_src_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    device_d_valid |-> src_hit(device_d[DPayW-HdrWidth-1 -: SourceWidth]));
`endif

endmodule

// File: tb/tb_tl_socket_m1.sv
// tb/tb_tl_socket_m1.sv - directed self-checking bench for tl_socket_m1 with three host links.

module tb_tl_socket_m1;

    localparam int AW = 3 + 3 + 3 + 4 + 16 + 8 + 1 + 64;
    localparam int BW = AW;
    localparam int CW = 3 + 3 + 3 + 4 + 16 + 1 + 64;
    localparam int DW = 3 + 3 + 3 + 4 + 2 + 1 + 1 + 64;
    localparam int EW = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [2:0][AW-1:0] host_a;
    logic [2:0]         host_a_valid, host_a_ready;
    logic [2:0][CW-1:0] host_c;
    logic [2:0]         host_c_valid, host_c_ready;
    logic [2:0][EW-1:0] host_e;
    logic [2:0]         host_e_valid, host_e_ready;
    logic [2:0][BW-1:0] host_b;
    logic [2:0]         host_b_valid, host_b_ready;
    logic [2:0][DW-1:0] host_d;
    logic [2:0]         host_d_valid, host_d_ready;
    logic [AW-1:0]      device_a;
    logic               device_a_valid, device_a_ready;
    logic [CW-1:0]      device_c;
    logic               device_c_valid, device_c_ready;
    logic [EW-1:0]      device_e;
    logic               device_e_valid, device_e_ready;
    logic [BW-1:0]      device_b;
    logic               device_b_valid, device_b_ready;
    logic [DW-1:0]      device_d;
    logic               device_d_valid, device_d_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_sel;
    logic done = 1'b0;

    always #5 clk_i = ~clk_i;

    tl_socket_m1 #(
        .SourceWidth(4), .SinkWidth(2), .AddrWidth(16), .DataWidth(64), .MaxSize(6),
        .NumLinks(3), .NumSourceRange(2),
        .SourceBase({4'd4, 4'd0}), .SourceMask({4'd3, 4'd3}), .SourceLink({2'd1, 2'd0})
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_a(host_a), .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
        .host_c(host_c), .host_c_valid(host_c_valid), .host_c_ready(host_c_ready),
        .host_e(host_e), .host_e_valid(host_e_valid), .host_e_ready(host_e_ready),
        .host_b(host_b), .host_b_valid(host_b_valid), .host_b_ready(host_b_ready),
        .host_d(host_d), .host_d_valid(host_d_valid), .host_d_ready(host_d_ready),
        .device_a(device_a), .device_a_valid(device_a_valid), .device_a_ready(device_a_ready),
        .device_c(device_c), .device_c_valid(device_c_valid), .device_c_ready(device_c_ready),
        .device_e(device_e), .device_e_valid(device_e_valid), .device_e_ready(device_e_ready),
        .device_b(device_b), .device_b_valid(device_b_valid), .device_b_ready(device_b_ready),
        .device_d(device_d), .device_d_valid(device_d_valid), .device_d_ready(device_d_ready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] mk_a(input logic [2:0] op, input logic [2:0] sz,
                                           input logic [3:0] src, input logic [63:0] data);
        return {op, 3'd0, sz, src, 16'h1000, 8'hff, 1'b0, data};
    endfunction

    function automatic logic [CW-1:0] mk_c(input logic [2:0] op, input logic [2:0] sz,
                                           input logic [3:0] src, input logic [63:0] data);
        return {op, 3'd0, sz, src, 16'h2000, 1'b0, data};
    endfunction

    function automatic logic [DW-1:0] mk_d(input logic [3:0] src);
        return {3'd1, 3'd0, 3'd3, src, 2'd1, 1'b0, 1'b0, 64'h0000_dddd_0000_dddd};
    endfunction

    function automatic logic [BW-1:0] mk_b(input logic [3:0] src);
        return {3'd6, 3'd0, 3'd6, src, 16'h0040, 8'hff, 1'b0, 64'h0};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_errors++;
            $error("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    initial begin
        rst_i = 1'b1;
        host_a = '0; host_a_valid = '0; host_c = '0; host_c_valid = '0;
        host_e = '0; host_e_valid = '0; host_b_ready = '0; host_d_ready = '0;
        device_a_ready = 1'b0; device_c_ready = 1'b0; device_e_ready = 1'b0;
        device_b = '0; device_b_valid = 1'b0; device_d = '0; device_d_valid = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        chk("reset_dev_a_valid", device_a_valid, 1'b0);
        chk("reset_dev_c_valid", device_c_valid, 1'b0);
        chk("reset_dev_e_valid", device_e_valid, 1'b0);
        chk("reset_host_a_ready", host_a_ready, 3'b000);
        chk("reset_host_d_valid", host_d_valid, 3'b000);
        chk("reset_dev_d_ready", device_d_ready, 1'b0);
        chk("reset_dev_b_ready", device_b_ready, 1'b0);

        device_a_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) host_a[k] = mk_a(3'd4, 3'd3, 4'(4 * k), 64'(32'hA0 + k));
            host_a_valid = 3'b111;
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_sel = 3'(1 << k);
                chk("cont_ready", host_a_ready, exp_sel);
                chk("cont_payload", device_a, mk_a(3'd4, 3'd3, 4'(4 * k), 64'(32'hA0 + k)));
                tick();
                host_a_valid[k] = 1'b0;
                #1;
            end
        end
        chk("cont_idle", device_a_valid, 1'b0);

        host_a[1] = mk_a(3'd0, 3'd6, 4'd4, 64'hB0);
        host_a_valid = 3'b010;
        #1;
        for (int b = 0; b < 8; b++) begin
            chk("burst_ready", host_a_ready, 3'b010);
            chk("burst_payload", device_a, mk_a(3'd0, 3'd6, 4'd4, 64'(32'hB0 + b)));
            tick();
            host_a[1] = mk_a(3'd0, 3'd6, 4'd4, 64'(32'hB0 + b + 1));
            if (b == 0) begin
                host_a[0] = mk_a(3'd4, 3'd3, 4'd0, 64'hC0);
                host_a_valid[0] = 1'b1;
            end
            #1;
        end
        host_a_valid[1] = 1'b0;
        #1;
        chk("burst_then_l0", host_a_ready, 3'b001);
        chk("burst_then_l0_pl", device_a, mk_a(3'd4, 3'd3, 4'd0, 64'hC0));
        tick();
        host_a_valid[0] = 1'b0;

        device_a_ready = 1'b0;
        host_a[0] = mk_a(3'd4, 3'd3, 4'd0, 64'hD0);
        host_a[2] = mk_a(3'd4, 3'd3, 4'd8, 64'hD2);
        host_a_valid = 3'b101;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", device_a_valid, 1'b1);
            chk("bp_payload", device_a, mk_a(3'd4, 3'd3, 4'd8, 64'hD2));
            chk("bp_ready", host_a_ready, 3'b000);
            tick();
            if (c == 0) begin
                host_a[1] = mk_a(3'd4, 3'd3, 4'd4, 64'hD1);
                host_a_valid[1] = 1'b1;
            end
            #1;
        end
        device_a_ready = 1'b1;
        #1;
        chk("bp_release_l2", host_a_ready, 3'b100);
        tick();
        host_a_valid[2] = 1'b0;
        #1;
        chk("bp_next_l0", host_a_ready, 3'b001);
        tick();
        host_a_valid[0] = 1'b0;
        #1;
        chk("bp_next_l1", host_a_ready, 3'b010);
        tick();
        host_a_valid[1] = 1'b0;

        host_d_ready = 3'b111;
        device_d = mk_d(4'd5);
        device_d_valid = 1'b1;
        #1;
        chk("route_d5_valid", host_d_valid, 3'b010);
        chk("route_d5_ready", device_d_ready, 1'b1);
        chk("route_d_bcast", host_d[2], mk_d(4'd5));
        host_d_ready = 3'b101;
        #1;
        chk("route_d5_ready_gated", device_d_ready, 1'b0);
        device_d = mk_d(4'd9);
        #1;
        chk("route_d9_nomatch", host_d_valid, 3'b001);
        chk("route_d9_ready", device_d_ready, 1'b1);
        device_d = mk_d(4'd7);
        #1;
        chk("route_d7_mask", host_d_valid, 3'b010);
        device_d_valid = 1'b0;
        #1;
        chk("route_d_idle", host_d_valid, 3'b000);
        host_b_ready = 3'b010;
        device_b = mk_b(4'd6);
        device_b_valid = 1'b1;
        #1;
        chk("route_b6_valid", host_b_valid, 3'b010);
        chk("route_b6_ready", device_b_ready, 1'b1);
        device_b_valid = 1'b0;
        tick();

        device_c_ready = 1'b1;
        device_e_ready = 1'b1;
        host_c[2] = mk_c(3'd7, 3'd6, 4'd8, 64'hE0);
        host_c_valid = 3'b100;
        host_e[1] = 2'd3;
        host_e_valid = 3'b010;
        #1;
        chk("e_ready", host_e_ready, 3'b010);
        chk("e_valid", device_e_valid, 1'b1);
        chk("e_payload", device_e, 2'd3);
        for (int b = 0; b < 8; b++) begin
            chk("c_burst_ready", host_c_ready, 3'b100);
            chk("c_burst_payload", device_c, mk_c(3'd7, 3'd6, 4'd8, 64'(32'hE0 + b)));
            tick();
            host_c[2] = mk_c(3'd7, 3'd6, 4'd8, 64'(32'hE0 + b + 1));
            if (b == 0) begin
                host_e_valid = 3'b000;
                host_c[0] = mk_c(3'd4, 3'd6, 4'd0, 64'h0);
                host_c[1] = mk_c(3'd4, 3'd6, 4'd4, 64'h0);
                host_c_valid[1:0] = 2'b11;
            end
            #1;
        end
        host_c_valid[2] = 1'b0;
        #1;
        chk("c_then_l0", host_c_ready, 3'b001);
        chk("c_then_l0_pl", device_c, mk_c(3'd4, 3'd6, 4'd0, 64'h0));
        tick();
        host_c_valid[0] = 1'b0;
        #1;
        chk("c_probeack_single", host_c_ready, 3'b010);
        tick();
        host_c_valid[1] = 1'b0;
        #1;
        chk("c_idle", device_c_valid, 1'b0);
        chk("e_idle", device_e_valid, 1'b0);

        host_a[1] = mk_a(3'd1, 3'd6, 4'd4, 64'hF0);
        host_a_valid = 3'b010;
        #1;
        chk("rst_burst_start", host_a_ready, 3'b010);
        tick();
        tick();
        rst_i = 1'b1;
        host_a_valid = 3'b000;
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_dev_a_valid", device_a_valid, 1'b0);
        chk("rst_host_a_ready", host_a_ready, 3'b000);
        host_a[0] = mk_a(3'd4, 3'd3, 4'd0, 64'h11);
        host_a[2] = mk_a(3'd4, 3'd3, 4'd8, 64'h22);
        host_a_valid = 3'b101;
        #1;
        chk("rst_unlocked_valid", device_a_valid, 1'b1);
        chk("rst_ptr_link0", host_a_ready, 3'b001);
        tick();
        host_a_valid[0] = 1'b0;
        #1;
        chk("rst_then_l2", host_a_ready, 3'b100);
        tick();
        host_a_valid = 3'b000;
        #1;

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tl_socket_m1.md
# tl_socket_m1

Many-to-one TileLink socket: merges `NumLinks` host-side links onto a single device link. The A, C and E request channels are arbitrated round-robin with burst locking. The B and D response channels are demultiplexed back to the originating host by a source-ID routing table. It sits between multiple masters (cores, DMA) and a shared crossbar or device port, mirroring the one-to-many socket on the device side.

## Interface
Parameters:
- `SourceWidth`, 1: source ID width, shared by all links; hosts must use disjoint source ranges.
- `SinkWidth`, 1: sink ID width.
- `AddrWidth`, 56: address width.
- `DataWidth`, 64: data bus width in bits.
- `MaxSize`, 6: log2 of the largest transfer in bytes.
- `NumLinks`, 1: number of host links.
- `LinkWidth`, localparam `vbits(NumLinks)`: link index width.
- `NumSourceRange`, 1: number of source routing entries.
- `SourceBase`, '0: `[NumSourceRange][SourceWidth]` base per entry.
- `SourceMask`, '0: don't-care bits per entry.
- `SourceLink`, '0: `[NumSourceRange][LinkWidth]` destination link per entry.

Ports (all channels carry standard TL valid/ready plus a payload struct):
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `host_{a,c,e}` / `host_{a,c,e}_valid` in `[NumLinks]`: requests from hosts.
- `host_{a,c,e}_ready` out `[NumLinks]`: request ready to hosts.
- `host_{b,d}` / `host_{b,d}_valid` out `[NumLinks]`: responses to hosts.
- `host_{b,d}_ready` in `[NumLinks]`: response ready from hosts.
- `device_{a,c,e}` / `device_{a,c,e}_valid` out: merged requests.
- `device_{a,c,e}_ready` in: device ready.
- `device_{b,d}` / `device_{b,d}_valid` in: responses from device.
- `device_{b,d}_ready` out: response ready to device.

## Operation
- **Arbiters:** one independent round-robin arbiter per channel for A, C and E.
  - Pointer resets to link 0.
  - After the last beat of a message from link k is accepted, link k+1 (mod `NumLinks`) gets highest priority.
- **A/C burst locking:**
  - Unlocked: the arbiter grants combinationally among valid links, and `device_x_valid` equals the winner's valid.
  - The grant locks in the first cycle `device_x_valid`=1. It stays locked across backpressure, so payload is stable until fire, and across all beats of a multi-beat message.
  - The lock releases in the cycle the last beat fires. The next grant may fire in the following cycle.
- **Beat count:**
  - A carries data when opcode ∈ {0,1,2,3}; C carries data when opcode ∈ {5,7}.
  - beats = 2^size / (DataWidth/8) when size > log2(DataWidth/8), else 1.
  - A per-channel beat counter of width `MaxSize - log2(DataWidth/8)` (minimum 1) counts down on each fire.
  - Data-less messages are single beat.
- **E channel:** always single beat; grant locks while valid is pending and releases on fire.
- **Ready gating:** `host_x_ready[i]` = `device_x_ready` && `select[i]`. Unselected links see ready=0.
- **B/D routing:**
  - Destination = `SourceLink[j]` of the highest-index j with `(source & ~SourceMask[j]) == SourceBase[j]`. No match routes to link 0.
  - `host_x_valid[i]` = `device_x_valid` && dest==i. `device_x_ready` = `host_x_ready[dest]`.
  - Payload is broadcast to all links unmodified.
  - D bursts need no lock because routing depends only on the stable source field.
- **Reset mid-burst:** locks, beat counters and pointers return to reset state; a partial burst is abandoned.

## Timing
- Zero-latency combinational forwarding on all channels; no payload registers.
- State: per A/C/E channel one lock flag, one selected-link one-hot and one RR pointer; A/C also hold a beat counter.
- Reset values:
  - All locks 0, pointers select link 0, counters 0.
  - With all inputs idle, every `*_valid` and `*_ready` output is 0.
- Simultaneous requests from all links: exactly one grant per message, in rotating order.
- Last-beat fire plus a new pending request in the same cycle: the new grant is taken the next cycle; no bubble is added beyond that cycle.
- `NumLinks`=1: arbiter degenerates to pass-through; lock logic still tracks beats.

## Configuration
- `TL_SOCKET_M1_ASSERT_EN`: when defined, compiles in concurrent assertions, checked on `clk_i` and disabled during `rst_i`:
  - B/D source matches at least one routing entry.
  - Selected link stays constant while locked.
  - `device_a`/`device_c` payload stays stable while valid && !ready.
  - Beat counter never underflows.
- When undefined, no assertions are present and functional behaviour is identical.

## Test plan
- **Contention:** DataWidth=64, NumLinks=3; links 0,1,2 each send Get (opcode 4, size 3) in the same cycle, device ready=1 → fires in order 0,1,2 on consecutive cycles; next round starts at link 0.
- **Burst lock:** link 1 sends PutFullData size 6 (8 beats) while link 0 requests throughout → 8 consecutive link-1 beats, then link 0.
- **Backpressure:** device_a_ready=0 for 5 cycles while links 0 and 2 are valid → winner's payload and valid stay stable; other links' ready=0.
- **Routing:** SourceBase={0,4}, SourceMask={3,3}, SourceLink={0,1}; D with source 5 → only `host_d_valid[1]`=1; source 9 (no match) → link 0.
- **C + E:** ReleaseData size 6 on link 2 while link 0 sends ProbeAck and link 1 sends E → C delivers link 2's 8 beats then link 0; E fires in the same cycle independently.
- **Reset:** assert `rst_i` at beat 3 of an 8-beat burst → next cycle all valids 0, lock cleared, pointer at link 0.
